// File: rtl/imem_port_arbiter.sv
// Purpose : arbitrates the single-port instruction memory between fetch (read) and the loader (write).
// Latency : handshake in cycle N, memory access and response in cycle N+1; grants are combinational.
// Backpressure: requesters hold req/addr until gnt; loader has priority but yields to fetch after
//               LOAD_BURST consecutive grants while fetch waits, so fetch is never starved.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   fetch_req/addr/gnt/flush      fetch request channel (word address)
//   fetch_rvalid/rdata/err        fetch response, one cycle after the grant
//   load_req/addr/wdata/gnt       loader write request channel
//   load_done/err                 loader completion, one cycle after the grant
//   mem_address/read_en/write_en/data_in   registered memory controls
//   mem_data_out                  memory read data, combinational from mem_address
//   stat_fetch_cnt/load_cnt/stall_cnt      only when IMEM_ARB_STATS_EN is defined
//
// Optional feature macro: IMEM_ARB_STATS_EN (adds free-running wrap-around statistics counters).

module imem_port_arbiter #(
  parameter int unsigned DEPTH      = 8192,
  parameter int unsigned LOAD_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch requester
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  input  logic        fetch_flush,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  output logic        fetch_err,
  // loader requester
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_wdata,
  output logic        load_gnt,
  output logic        load_done,
  output logic        load_err,
  // memory side
  output logic [31:0] mem_address,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_fetch_cnt,
  output logic [31:0] stat_load_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH);
  localparam logic [3:0]  BURST_L = 4'(LOAD_BURST);

  // The state names the memory phase of the current cycle, i.e. the outcome
  // of the grant taken at the previous edge.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ERR_R,
    ST_ERR_W
  } state_t;

  state_t     state;
  logic [3:0] burst_cnt;

  logic burst_full;
  logic fetch_oor;
  logic load_oor;

  assign burst_full = (burst_cnt == BURST_L);

  // Full 32-bit unsigned compare: any address at or above DEPTH is rejected,
  // including ones whose low bits would alias into the array.
  assign fetch_oor  = (fetch_addr >= DEPTH_L);
  assign load_oor   = (load_addr  >= DEPTH_L);

  // Loader wins unless it has used up its burst while fetch is waiting.
  // The two grants are mutually exclusive by construction.
  assign fetch_gnt  = ~rst & fetch_req & (~load_req | burst_full);
  assign load_gnt   = ~rst & load_req  & ~(fetch_req & burst_full);

  // Bus-phase FSM with registered memory controls. On an out-of-range grant
  // the address and data registers are left untouched so the memory sees no
  // new activity; only the enables drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      burst_cnt    <= 4'd0;
      mem_address  <= 32'd0;
      mem_data_in  <= 32'd0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;

      if (fetch_gnt) begin
        if (fetch_oor) begin
          state <= ST_ERR_R;
        end else begin
          state       <= ST_READ;
          mem_address <= fetch_addr;
          mem_read_en <= 1'b1;
        end
      end else if (load_gnt) begin
        if (load_oor) begin
          state <= ST_ERR_W;
        end else begin
          state        <= ST_WRITE;
          mem_address  <= load_addr;
          mem_data_in  <= load_wdata;
          mem_write_en <= 1'b1;
        end
      end else begin
        state <= ST_IDLE;
      end

      // Counts loader grants taken while fetch waits. It cannot pass
      // BURST_L: at BURST_L with fetch pending, fetch is the one granted.
      if (fetch_gnt || !fetch_req) begin
        burst_cnt <= 4'd0;
      end else if (load_gnt) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  // Responses decode the current phase. They are masked while rst is high so
  // a response due in a reset cycle is dropped; a write already in its WRITE
  // phase still reaches memory because mem_write_en is registered.
  always_comb begin
    fetch_rvalid = 1'b0;
    fetch_rdata  = 32'd0;
    fetch_err    = 1'b0;
    load_done    = 1'b0;
    load_err     = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_READ: begin
          fetch_rvalid = ~fetch_flush;
          fetch_rdata  = mem_data_out;
        end
        ST_ERR_R: begin
          fetch_rvalid = ~fetch_flush;
          fetch_err    = ~fetch_flush;
        end
        ST_WRITE: begin
          load_done = 1'b1;
        end
        ST_ERR_W: begin
          load_done = 1'b1;
          load_err  = 1'b1;
        end
        default: begin
          fetch_rvalid = 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_ARB_STATS_EN
  // Free-running counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch_cnt <= 32'd0;
      stat_load_cnt  <= 32'd0;
      stat_stall_cnt <= 32'd0;
    end else begin
      if (fetch_req && fetch_gnt) begin
        stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
      end
      if (load_req && load_gnt) begin
        stat_load_cnt <= stat_load_cnt + 32'd1;
      end
      if (fetch_req && !fetch_gnt) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
